// File: rtl/systolic_sequencer.sv
// systolic_sequencer: job controller that buffers an NxN A/B operand pair, feeds systolic_array and returns its result beats
// Ports: clk/rst_n (async active-low); load_* host operand-row port; start/busy/done/err job control;
//   sa_clr_n, sa_valid_in, sa_a_out, sa_b_out drive the array; sa_valid_out, sa_c_in come back from it;
//   res_valid/res_ready/res_row/res_data return captured beats to the host.
// Optional: define SEQ_TIMEOUT_EN for a FLUSH/COLLECT watchdog that pulses err after TIMEOUT idle cycles.
module systolic_sequencer #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_valid,
    output logic                            load_ready,
    input  logic                            load_sel,
    input  logic [$clog2(N_SIZE)-1:0]       load_row,
    input  logic [N_SIZE*DATAWIDTH-1:0]     load_data,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            sa_clr_n,
    output logic                            sa_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]     sa_a_out,
    output logic [N_SIZE*DATAWIDTH-1:0]     sa_b_out,
    input  logic                            sa_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0]   sa_c_in,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [$clog2(N_SIZE)-1:0]       res_row,
    output logic [N_SIZE*2*DATAWIDTH-1:0]   res_data
);
    localparam int RW = $clog2(N_SIZE);
    localparam int CW = RW + 1;
    localparam int DW = DATAWIDTH;
    localparam int W  = N_SIZE * DATAWIDTH;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, COLLECT, DRAIN} state_t;

    state_t            state;
    logic [W-1:0]      a_buf [N_SIZE];
    logic [W-1:0]      b_buf [N_SIZE];
    logic [2*W-1:0]    r_buf [N_SIZE];
    logic [N_SIZE-1:0] a_mask, b_mask;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     nk;
    logic [W-1:0]      a_nxt, b_nxt;
    logic              wr;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign wr = state == IDLE && load_valid && {1'b0, load_row} < CW'(N_SIZE);

    // nk is the next FEED beat (column of A / row of B) or the next DRAIN read index
    always_comb begin
        nk = (state == CLEAR) ? '0 : cnt[RW-1:0] + RW'(1);
        b_nxt = b_buf[nk];
        a_nxt = '0;
        for (int i = 0; i < N_SIZE; i++) a_nxt[i*DW +: DW] = a_buf[i][nk*DW +: DW];
    end

    always_ff @(posedge clk) begin
        if (wr && !load_sel) a_buf[load_row] <= load_data;
        if (wr && load_sel) b_buf[load_row] <= load_data;
        if ((state == FLUSH || state == COLLECT) && sa_valid_out) r_buf[cnt[RW-1:0]] <= sa_c_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_mask      <= '0;
            b_mask      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            load_ready  <= 1'b1;
            sa_clr_n    <= 1'b1;
            sa_valid_in <= 1'b0;
            sa_a_out    <= '0;
            sa_b_out    <= '0;
            res_valid   <= 1'b0;
            res_row     <= '0;
            res_data    <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd          <= '0;
`endif
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            sa_clr_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (wr && !load_sel) a_mask[load_row] <= 1'b1;
                    if (wr && load_sel) b_mask[load_row] <= 1'b1;
                    // masks sampled before this cycle's write
                    if (start && &a_mask && &b_mask) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        sa_clr_n   <= 1'b0;
                    end
                end
                CLEAR: begin
                    state       <= FEED;
                    cnt         <= '0;
                    sa_valid_in <= 1'b1;
                    sa_a_out    <= a_nxt;
                    sa_b_out    <= b_nxt;
                end
                FEED: begin
                    if (cnt == CW'(N_SIZE - 1)) begin
                        state       <= FLUSH;
                        cnt         <= '0;
                        sa_valid_in <= 1'b0;
                        sa_a_out    <= '0;
                        sa_b_out    <= '0;
`ifdef SEQ_TIMEOUT_EN
                        wd          <= '0;
`endif
                    end else begin
                        cnt      <= cnt + CW'(1);
                        sa_a_out <= a_nxt;
                        sa_b_out <= b_nxt;
                    end
                end
                FLUSH, COLLECT: begin
                    if (sa_valid_out) begin
`ifdef SEQ_TIMEOUT_EN
                        wd <= '0;
`endif
                        if (cnt == CW'(N_SIZE - 1)) begin
                            state     <= DRAIN;
                            cnt       <= '0;
                            res_valid <= 1'b1;
                            res_row   <= '0;
                            // with a single-beat job, beat 0 is still being written
                            res_data  <= (cnt == '0) ? sa_c_in : r_buf[0];
                        end else begin
                            state <= COLLECT;
                            cnt   <= cnt + CW'(1);
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wd == TW'(TIMEOUT - 1)) begin
                        state      <= IDLE;
                        err        <= 1'b1;
                        a_mask     <= '0;
                        b_mask     <= '0;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        wd <= wd + TW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (res_ready) begin
                        if (cnt == CW'(N_SIZE - 1)) begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            a_mask     <= '0;
                            b_mask     <= '0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            res_valid  <= 1'b0;
                            res_row    <= '0;
                            res_data   <= '0;
                            cnt        <= '0;
                        end else begin
                            cnt      <= cnt + CW'(1);
                            res_row  <= nk;
                            res_data <= r_buf[nk];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed table-driven bench for systolic_sequencer with N_SIZE=5, DATAWIDTH=16
module tb_systolic_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         load_sel = 1'b0;
    logic [2:0]   load_row = '0;
    logic [79:0]  load_data = '0;
    logic         start = 1'b0;
    logic         busy, done, err, sa_clr_n, sa_valid_in;
    logic [79:0]  sa_a_out, sa_b_out;
    logic         sa_valid_out = 1'b0;
    logic [159:0] sa_c_in = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [2:0]   res_row;
    logic [159:0] res_data;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [79:0] a;
        logic [79:0] b;
    } feed_t;

    typedef struct packed {
        logic       rdy;
        logic [2:0] row;
    } drain_t;

    feed_t  fv [5];
    drain_t dv [8];

    systolic_sequencer #(.DATAWIDTH(16), .N_SIZE(5), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
        .load_row(load_row), .load_data(load_data),
        .start(start), .busy(busy), .done(done), .err(err),
        .sa_clr_n(sa_clr_n), .sa_valid_in(sa_valid_in),
        .sa_a_out(sa_a_out), .sa_b_out(sa_b_out),
        .sa_valid_out(sa_valid_out), .sa_c_in(sa_c_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_row(res_row), .res_data(res_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] ident_row(input int r);
        logic [79:0] v = '0;
        v[r*16 +: 16] = 16'd1;
        return v;
    endfunction

    function automatic logic [79:0] b_row(input int r);
        logic [79:0] v;
        for (int j = 0; j < 5; j++) v[j*16 +: 16] = 16'(10 * r + j);
        return v;
    endfunction

    function automatic logic [159:0] beat(input int b);
        logic [159:0] v;
        for (int e = 0; e < 5; e++) v[e*32 +: 32] = 32'h11 * (b + 1) + (e << 16);
        return v;
    endfunction

    task automatic load(input logic sel, input logic [2:0] row, input logic [79:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = row;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int r = 0; r < 5; r++) load(1'b0, 3'(r), ident_row(r));
        for (int r = 0; r < 5; r++) load(1'b1, 3'(r), b_row(r));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int vpat [6] = '{1, 1, 0, 1, 1, 1};
        int bi;
        for (int k = 0; k < 5; k++) begin
            fv[k].a = ident_row(k);
            fv[k].b = b_row(k);
        end
        dv[0] = '{1'b1, 3'd0};
        dv[1] = '{1'b0, 3'd1};
        dv[2] = '{1'b0, 3'd1};
        dv[3] = '{1'b1, 3'd1};
        dv[4] = '{1'b1, 3'd2};
        dv[5] = '{1'b0, 3'd3};
        dv[6] = '{1'b1, 3'd3};
        dv[7] = '{1'b1, 3'd4};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_clr_n", sa_clr_n, 1);
        chk("rst_valid_in", sa_valid_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_a_out", sa_a_out, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_row", res_row, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 5; r++) load(1'b0, 3'(r), ident_row(r));
        for (int r = 0; r < 5; r++) if (r != 3) load(1'b1, 3'(r), b_row(r));
        load(1'b1, 3'd7, {5{16'hBEEF}});
        pulse_start();
        chk("start_missing_busy", busy, 0);
        chk("start_missing_clr", sa_clr_n, 1);
        @(negedge clk);
        chk("start_missing_busy2", busy, 0);

        load(1'b1, 3'd3, b_row(3));
        pulse_start();
        chk("clear_clr_n", sa_clr_n, 0);
        chk("clear_busy", busy, 1);
        chk("clear_load_ready", load_ready, 0);
        chk("clear_valid_in", sa_valid_in, 0);
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_row   = 3'd0;
        load_data  = {5{16'hFFFF}};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("feed%0d_valid", k), sa_valid_in, 1);
            chk($sformatf("feed%0d_clr_n", k), sa_clr_n, 1);
            chk($sformatf("feed%0d_a", k), sa_a_out, fv[k].a);
            chk($sformatf("feed%0d_b", k), sa_b_out, fv[k].b);
        end
        load_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid_in", sa_valid_in, 0);
        chk("flush_a", sa_a_out, 0);
        chk("flush_b", sa_b_out, 0);
        chk("flush_busy", busy, 1);
        chk("flush_res_valid", res_valid, 0);

        bi = 0;
        for (int p = 0; p < 6; p++) begin
            sa_valid_out = vpat[p][0];
            sa_c_in = vpat[p] != 0 ? beat(bi) : {5{32'hDEADDEAD}};
            @(negedge clk);
            if (vpat[p] != 0) bi++;
        end
        sa_valid_out = 1'b0;
        sa_c_in = '0;

        for (int e = 0; e < 8; e++) begin
            res_ready = dv[e].rdy;
            chk($sformatf("drain%0d_valid", e), res_valid, 1);
            chk($sformatf("drain%0d_row", e), res_row, dv[e].row);
            chk($sformatf("drain%0d_data", e), res_data, beat(int'(dv[e].row)));
            chk($sformatf("drain%0d_done", e), done, 0);
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_res_valid", res_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_load_ready", load_ready, 1);
        @(negedge clk);
        chk("done_once", done, 0);

        pulse_start();
        chk("masks_cleared_after_job", busy, 0);

        load_all();
        pulse_start();
        repeat (2) @(negedge clk);
        chk("midfeed_valid_in", sa_valid_in, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid_in", sa_valid_in, 0);
        chk("arst_clr_n", sa_clr_n, 1);
        chk("arst_load_ready", load_ready, 1);
        chk("arst_a_out", sa_a_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        chk("arst_masks_cleared", busy, 0);

`ifdef SEQ_TIMEOUT_EN
        begin
            int n = 0;
            load_all();
            pulse_start();
            repeat (5) @(negedge clk);
            while (!err && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, 65);
            chk("timeout_busy", busy, 0);
            chk("timeout_res_valid", res_valid, 0);
            chk("timeout_done", done, 0);
            @(negedge clk);
            chk("timeout_err_pulse", err, 0);
            pulse_start();
            chk("timeout_masks_cleared", busy, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
